// File: rtl/sp_ram_pkg.sv
// Shared types and helpers for the byte-enable single-port RAM.
package sp_ram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  // Widest word the merge helper handles; callers size-cast in and out.
  localparam int MERGE_W = 1024;
  localparam int MBE_W   = MERGE_W / 8;

  function automatic logic [MERGE_W-1:0] byte_merge(
    input logic [MERGE_W-1:0] old_w,
    input logic [MERGE_W-1:0] new_w,
    input logic [MBE_W-1:0]   be
  );
    logic [MERGE_W-1:0] r;
    r = old_w;
    for (int k = 0; k < MBE_W; k++) begin
      if (be[k]) r[8*k +: 8] = new_w[8*k +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/sp_ram_be.sv
// Single-port byte-enable RAM with registered read data and a
// self-clearing sweep after reset or on a clr request.
module sp_ram_be
  import sp_ram_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 6,
  parameter int RDW_MODE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     din,
  input  logic                  clr,
  output logic [DATA_W-1:0]     dout,
  output logic                  dout_valid,
  output logic                  ready
);

  localparam int BE_W  = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   cnt;
  logic                clearing;
  logic                acc;
  logic                mem_wr;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wd;
  logic [BE_W-1:0]     mem_be;
  logic [DATA_W-1:0]   merged;

  logic [DATA_W-1:0]   mem [DEPTH];

  assign clearing = (state == ST_CLEAR);
  assign acc      = req && ready && !clr && (state == ST_IDLE);

  always_comb begin
    state_nx = state;
    case (state)
      ST_CLEAR: if (cnt == {ADDR_W{1'b1}}) state_nx = ST_IDLE;
      ST_IDLE:  if (clr) state_nx = ST_CLEAR;
      default:  state_nx = ST_CLEAR;
    endcase
  end

  // The sweep and user writes share the one port; the sweep owns it in CLEAR.
  assign mem_addr = clearing ? cnt : addr;
  assign mem_wd   = clearing ? '0 : din;
  assign mem_be   = clearing ? '1 : be;
  assign mem_wr   = !rst && (clearing || (acc && we));

  assign merged = DATA_W'(byte_merge(MERGE_W'(mem[addr]), MERGE_W'(din), MBE_W'(be)));

  always_ff @(posedge clk) begin
    if (mem_wr) begin
      for (int k = 0; k < BE_W; k++) begin
        if (mem_be[k]) mem[mem_addr][8*k +: 8] <= mem_wd[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_CLEAR;
      cnt        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      ready      <= 1'b0;
    end else begin
      state      <= state_nx;
      ready      <= (state_nx == ST_IDLE);
      dout_valid <= acc;
      if (clearing) cnt <= cnt + 1'b1;
      if (acc) dout <= (RDW_MODE == RDW_NEW && we) ? merged : mem[addr];
    end
  end

endmodule

// File: tb/tb_sp_ram_be.sv
// Directed bench for sp_ram_be: one read-first and one write-first instance
// driven by the same stimulus.
module tb_sp_ram_be;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we  = 1'b0;
  logic [3:0]  be  = 4'h0;
  logic [3:0]  addr = 4'h0;
  logic [31:0] din = 32'h0;
  logic        clr = 1'b0;
  logic [31:0] dout0, dout1;
  logic        vld0, vld1, rdy0, rdy1;

  int checks   = 0;
  int failures = 0;

  logic [31:0] model [16];

  always #5 clk = ~clk;

  sp_ram_be #(.DATA_W(32), .ADDR_W(4), .RDW_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .req(req), .we(we), .be(be), .addr(addr), .din(din),
    .clr(clr), .dout(dout0), .dout_valid(vld0), .ready(rdy0)
  );

  sp_ram_be #(.DATA_W(32), .ADDR_W(4), .RDW_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .req(req), .we(we), .be(be), .addr(addr), .din(din),
    .clr(clr), .dout(dout1), .dout_valid(vld1), .ready(rdy1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] n,
                                      input logic [3:0] b);
    logic [31:0] r;
    r = o;
    for (int k = 0; k < 4; k++) if (b[k]) r[8*k +: 8] = n[8*k +: 8];
    return r;
  endfunction

  task automatic acc(input logic w, input logic [3:0] a, input logic [31:0] d,
                     input logic [3:0] b);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; din = d; be = b;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    @(negedge clk);
    req = 1'b0; we = 1'b0; be = 4'h0;
  endtask

  task automatic count_ready_low(input string tag);
    int n;
    n = 0;
    while (!rdy0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_ready_cycles"}, 32'(n), 32'd16);
    check({tag, "_ready1"}, 32'(rdy1), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic seen;
    logic [3:0]  a, last_a;
    logic [31:0] d, e_old, e_new;
    logic [3:0]  b;

    // Reset for two cycles
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(rdy0), 32'd0);
    check("rst_dout", dout0, 32'h0);
    check("rst_valid", 32'(vld0), 32'd0);
    rst = 1'b0;
    count_ready_low("init");

    for (int i = 0; i < 16; i++) begin
      acc(1'b0, 4'(i), 32'h0, 4'h0);
      check($sformatf("zero_rd%0d_dut0", i), dout0, 32'h0);
      check($sformatf("zero_rd%0d_dut1", i), dout1, 32'h0);
      check($sformatf("zero_rd%0d_vld", i), 32'(vld0 & vld1), 32'd1);
    end
    idle();

    // Byte enables
    acc(1'b1, 4'd3, 32'hAABBCCDD, 4'b1111);
    acc(1'b1, 4'd3, 32'h11223344, 4'b0101);
    check("be_wr_old", dout0, 32'hAABBCCDD);
    check("be_wr_new", dout1, 32'hAA22CC44);
    acc(1'b0, 4'd3, 32'h0, 4'h0);
    check("be_rd_dut0", dout0, 32'hAA22CC44);
    check("be_rd_dut1", dout1, 32'hAA22CC44);
    check("be_rd_vld", 32'(vld0), 32'd1);
    idle();
    @(posedge clk); #1;
    check("vld_drop", 32'(vld0 | vld1), 32'd0);

    // Read during write
    acc(1'b1, 4'd5, 32'h12345678, 4'b1111);
    acc(1'b1, 4'd5, 32'hFFFFFFFF, 4'b1111);
    check("rdw_old", dout0, 32'h12345678);
    check("rdw_new", dout1, 32'hFFFFFFFF);
    acc(1'b1, 4'd5, 32'h00000000, 4'b0000);
    check("be0_wr_old", dout0, 32'hFFFFFFFF);
    check("be0_wr_new", dout1, 32'hFFFFFFFF);
    acc(1'b0, 4'd5, 32'h0, 4'h0);
    check("be0_rd", dout0, 32'hFFFFFFFF);
    idle();
    repeat (3) begin @(posedge clk); #1; end
    check("hold_dout0", dout0, 32'hFFFFFFFF);
    check("hold_dout1", dout1, 32'hFFFFFFFF);
    check("hold_vld", 32'(vld0 | vld1), 32'd0);

    // clr wins over a same-cycle write; req and clr ignored during the sweep
    @(negedge clk);
    clr = 1'b1; req = 1'b1; we = 1'b1; addr = 4'd2; din = 32'hDEADBEEF; be = 4'hF;
    @(posedge clk); #1;
    check("clr_vld", 32'(vld0 | vld1), 32'd0);
    check("clr_ready", 32'(rdy0), 32'd0);
    n = 1;
    seen = 1'b0;
    clr = 1'b0;
    while (!rdy0 && n < 100) begin
      clr = (n == 5);
      @(posedge clk); #1;
      seen = seen | vld0 | vld1;
      if (!rdy0) n++;
    end
    clr = 1'b0;
    idle();
    check("clr_ready_cycles", 32'(n), 32'd16);
    check("clr_no_vld", 32'(seen), 32'd0);
    check("clr_hold_dout", dout0, 32'hFFFFFFFF);
    acc(1'b0, 4'd2, 32'h0, 4'h0);
    check("clr_rd2_dut0", dout0, 32'h0);
    check("clr_rd2_dut1", dout1, 32'h0);
    acc(1'b0, 4'd3, 32'h0, 4'h0);
    check("clr_rd3", dout0, 32'h0);
    idle();

    // Reset while the sweep is at address 9
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_ready", 32'(rdy0), 32'd0);
    check("midrst_dout", dout0, 32'h0);
    rst = 1'b0;
    count_ready_low("midrst");

    // Back-to-back alternating write/read against a reference model
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
    last_a = 4'h0;
    for (int i = 0; i < 32; i++) begin
      if (i % 2 == 0) begin
        a = 4'((i * 5 + 3) % 16);
        d = 32'h9E3779B9 * 32'(i + 1);
        b = 4'((i * 7 + 1) % 16);
        e_old = model[a];
        e_new = mrg(model[a], d, b);
        acc(1'b1, a, d, b);
        check($sformatf("b2b_wr%0d_old", i), dout0, e_old);
        check($sformatf("b2b_wr%0d_new", i), dout1, e_new);
        model[a] = e_new;
        last_a = a;
      end else begin
        a = (i % 4 == 1) ? last_a : 4'((i * 3) % 16);
        acc(1'b0, a, 32'h0, 4'h0);
        check($sformatf("b2b_rd%0d_dut0", i), dout0, model[a]);
        check($sformatf("b2b_rd%0d_dut1", i), dout1, model[a]);
      end
      check($sformatf("b2b_vld%0d", i), 32'(vld0 & vld1), 32'd1);
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sp_ram_be.md
SP_RAM_BE -- requirements
Module: sp_ram_be

Interface
REQ-001 SHALL have parameter DATA_W, default 32, word width in bits; legal values are multiples of 8.
REQ-002 SHALL have parameter ADDR_W, default 6, address width; depth = 2**ADDR_W words.
REQ-003 SHALL have parameter RDW_MODE, default 0, read-during-write return: 0 = old data (read-first), 1 = merged new data (write-first).
REQ-004 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port req, input, 1, access request.
REQ-007 SHALL have port we, input, 1, 1 = write, 0 = read.
REQ-008 SHALL have port be, input, DATA_W/8, byte enables for writes; bit k covers din[8k+7:8k].
REQ-009 SHALL have port addr, input, ADDR_W, word address.
REQ-010 SHALL have port din, input, DATA_W, write data.
REQ-011 SHALL have port clr, input, 1, single-cycle request to clear the whole array.
REQ-012 SHALL have port dout, output, DATA_W, registered read data.
REQ-013 SHALL have port dout_valid, output, 1, one-cycle pulse marking new dout.
REQ-014 SHALL have port ready, output, 1, registered; 1 = array accepts accesses.

Function
REQ-015 SHALL implement a two-state FSM: CLEAR (ready=0) and IDLE (ready=1).
REQ-016 SHALL, in CLEAR, write zero to one word per cycle using an ADDR_W-bit clear counter from 0 upward.
REQ-017 SHALL leave CLEAR for IDLE on the cycle after the counter writes address 2**ADDR_W-1, with the counter wrapping to 0; clearing takes exactly 2**ADDR_W cycles.
REQ-018 SHALL accept an access when req=1 && ready=1 && clr=0 on a clock edge.
REQ-019 SHALL ignore req in CLEAR: no array change, no dout_valid.
REQ-020 SHALL, on an accepted write, update only the bytes with be=1 at addr on that edge; be=0 means no bytes change.
REQ-021 SHALL, on every accepted access (read or write), load dout and pulse dout_valid high on the following edge (latency 1).
REQ-022 SHALL return the stored word for a read; for a write SHALL return the pre-write word when RDW_MODE=0 and the byte-merged word when RDW_MODE=1.
REQ-023 SHALL hold dout unchanged between accepted accesses, including throughout CLEAR.
REQ-024 SHALL, on clr=1 in IDLE, drop any same-cycle req (clr priority) and enter CLEAR on the next edge.
REQ-025 SHALL ignore clr while already in CLEAR; the sweep continues uninterrupted.
REQ-026 SHALL support back-to-back accesses every cycle, including a write then a read to the same address (the read returns the written data).

Reset
REQ-027 SHALL, while rst=1 on an edge, set state=CLEAR, clear counter=0, dout=0, dout_valid=0, ready=0.
REQ-028 SHALL restart the sweep at address 0 when rst asserts mid-clear or mid-access; an access coincident with rst SHALL be discarded.
REQ-029 SHALL raise ready exactly 2**ADDR_W cycles after the first edge with rst=0.
REQ-030 SHALL rely only on the sweep, not a reset of the array, to zero memory, so the array remains inferable as block RAM.

Structure
REQ-031 SHALL take the FSM state type and the RDW_MODE constants (RDW_OLD=0, RDW_NEW=1) from shared package sp_ram_pkg, together with a pure byte-merge function (old, new, be).
REQ-032 SHALL be a single flat module with no sub-module; the array SHALL be exactly one memory with one read/write port.

Verification (DATA_W=32, ADDR_W=4)
REQ-033 SHALL check reset: pulse rst for 2 cycles -> ready=0 for exactly 16 cycles and then 1; reads of addresses 0..15 return 0x00000000.
REQ-034 SHALL check byte enables: write 0xAABBCCDD with be=4'b1111 to addr 3, then write 0x11223344 with be=4'b0101 -> a read of addr 3 returns 0xAA22CC44 with dout_valid on the edge after acceptance.
REQ-035 SHALL check read-during-write: with addr 5 holding 0x12345678, write 0xFFFFFFFF with be=4'b1111 -> dout=0x12345678 when RDW_MODE=0 and 0xFFFFFFFF when RDW_MODE=1.
REQ-036 SHALL check clr priority: clr=1 together with a req write to addr 2 -> no write occurs, no dout_valid, ready low for 16 cycles, and addr 2 reads 0 afterwards.
REQ-037 SHALL check reset mid-clear: assert rst when the clear counter is 9 -> the sweep restarts and ready rises 16 cycles after rst deasserts.
REQ-038 SHALL check back-to-back traffic: 32 consecutive alternating write/read cycles -> every read matches the reference model and dout_valid is high on every cycle after the first.
